ex_issue_ctrl: RTL and testbench

- Sequencing controller for the EX stage of the RV32IC pipeline; owns the single EX slot in front of the ALU.
- Performs valid/ready handshakes with ID (upstream) and MEM (downstream).
- Generates the ALU operand-latch enable, detects load-use hazards and inserts bubbles.
- Converts ALU branch resolution into a one-cycle redirect followed by a timed flush of the younger stages.

---
 rtl/ex_issue_ctrl.sv | 125 ++++++++++++
 tb/tb_ex_issue_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ex_issue_ctrl.sv
// EX-slot sequencing controller: ID/MEM handshakes, load-use bubbles, branch redirect and timed flush.
// Optional performance counters are compiled in with `define EX_PERF_CNT_EN.
module ex_issue_ctrl #(
  parameter int ALUOP_W      = 7,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_id_valid,
  output logic               o_id_ready,
  input  logic [ALUOP_W-1:0] i_id_ALUop,
  input  logic [4:0]         i_id_rd,
  input  logic               i_id_regwrite,
  input  logic [4:0]         i_id_rs1,
  input  logic [4:0]         i_id_rs2,
  output logic               o_ex_en,
  input  logic               i_alu_branch,
  output logic               o_mem_valid,
  input  logic               i_mem_ready,
  output logic               o_redirect,
  output logic               o_flush,
  output logic [ALUOP_W-1:0] o_ex_op
`ifdef EX_PERF_CNT_EN
  ,
  output logic [31:0]        o_bubble_cnt,
  output logic [31:0]        o_flush_cnt
`endif
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_FLUSH   = 1'b1;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  logic [0:0]         state;
  logic [3:0]         flush_ctr;
  logic               ex_valid;
  logic [ALUOP_W-1:0] ex_op;
  logic [4:0]         ex_rd;
  logic               ex_regwrite;
  logic               retire;
  logic               hazard;
  logic               is_jump;
  logic               is_branch;
  logic               is_load;

  assign is_jump     = (ex_op == ALUOP_W'(2)) || (ex_op == ALUOP_W'(3));
  assign is_branch   = (ex_op >= ALUOP_W'(4)) && (ex_op <= ALUOP_W'(9));
  assign is_load     = (ex_op >= ALUOP_W'(10)) && (ex_op <= ALUOP_W'(14));
  assign o_mem_valid = ex_valid;
  assign o_ex_op     = ex_op;

  // Handshake, hazard and redirect decode for the current cycle
  always_comb begin
    retire     = ex_valid & i_mem_ready;
    o_redirect = retire & (is_jump | (is_branch & i_alu_branch));
    hazard     = ex_valid & is_load & ex_regwrite & (ex_rd != 5'd0) & i_id_valid &
                 ((i_id_rs1 == ex_rd) | (i_id_rs2 == ex_rd));
    o_id_ready = 1'b0;
    o_flush    = 1'b0;
    case (state)
      ST_RUN: begin
        // Hazard blocks even a retiring load, giving exactly one bubble
        o_id_ready = o_redirect | (~hazard & (~ex_valid | retire));
        o_flush    = 1'b0;
      end
      ST_FLUSH: begin
        o_id_ready = 1'b1;
        o_flush    = 1'b1;
      end
      default: begin
        o_id_ready = 1'b0;
        o_flush    = 1'b0;
      end
    endcase
    o_ex_en = i_id_valid & o_id_ready & ~o_redirect & (state == ST_RUN);
  end

  // EX slot, sequencing state and flush timer
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_valid    <= 1'b0;
      ex_op       <= '0;
      ex_rd       <= 5'd0;
      ex_regwrite <= 1'b0;
      state       <= ST_RUN;
      flush_ctr   <= 4'd0;
    end else if (o_redirect) begin
      ex_valid  <= 1'b0;
      state     <= ST_FLUSH;
      flush_ctr <= FLUSH_INIT;
    end else if (state == ST_FLUSH) begin
      if (flush_ctr <= 4'd1) begin
        state     <= ST_RUN;
        flush_ctr <= 4'd0;
      end else begin
        flush_ctr <= flush_ctr - 4'd1;
      end
    end else if (o_ex_en) begin
      ex_valid    <= 1'b1;
      ex_op       <= i_id_ALUop;
      ex_rd       <= i_id_rd;
      ex_regwrite <= i_id_regwrite;
    end else if (retire) begin
      ex_valid <= 1'b0;
    end
  end

`ifdef EX_PERF_CNT_EN
  // Bubble and redirect event counters, wrapping naturally at 2^32
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_bubble_cnt <= 32'd0;
      o_flush_cnt  <= 32'd0;
    end else begin
      if (hazard & ~o_redirect) begin
        o_bubble_cnt <= o_bubble_cnt + 32'd1;
      end
      if (o_redirect) begin
        o_flush_cnt <= o_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed test-plan sequences plus randomized traffic, all checked cycle by cycle
// against a behavioural model of the EX slot.
module tb_ex_issue_ctrl;
  localparam int AW = 7;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic          id_ready;
  logic [AW-1:0] id_op;
  logic [4:0]    id_rd;
  logic          id_rw;
  logic [4:0]    id_rs1;
  logic [4:0]    id_rs2;
  logic          ex_en;
  logic          alu_branch;
  logic          mem_valid;
  logic          mem_ready;
  logic          redirect;
  logic          flush;
  logic [AW-1:0] ex_op;
`ifdef EX_PERF_CNT_EN
  logic [31:0]   bubble_cnt;
  logic [31:0]   flush_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: the slot contents and remaining flush cycles
  bit        m_valid;
  int        m_op;
  int        m_rd;
  bit        m_rw;
  int        flush_left;
  longint    m_bubbles;
  longint    m_flushes;

  ex_issue_ctrl #(.ALUOP_W(AW), .FLUSH_CYCLES(FC)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_id_valid(id_valid), .o_id_ready(id_ready), .i_id_ALUop(id_op),
    .i_id_rd(id_rd), .i_id_regwrite(id_rw), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .o_ex_en(ex_en), .i_alu_branch(alu_branch), .o_mem_valid(mem_valid),
    .i_mem_ready(mem_ready), .o_redirect(redirect), .o_flush(flush), .o_ex_op(ex_op)
`ifdef EX_PERF_CNT_EN
    , .o_bubble_cnt(bubble_cnt), .o_flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model
  task automatic cyc(input bit v, input int op, input int rd, input bit rw,
                     input int rs1, input int rs2, input bit br, input bit mr, input bit r);
    bit e_ret, e_redir, e_haz, e_ready, e_en, e_flush, jmp, bra, ld;
    @(negedge clk);
    rst = r; id_valid = v; id_op = AW'(op); id_rd = 5'(rd); id_rw = rw;
    id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); alu_branch = br; mem_ready = mr;
    #1;
    jmp     = (m_op == 2) || (m_op == 3);
    bra     = (m_op >= 4) && (m_op <= 9);
    ld      = (m_op >= 10) && (m_op <= 14);
    e_flush = flush_left > 0;
    e_ret   = m_valid && mr;
    e_redir = e_ret && (jmp || (bra && br));
    e_haz   = m_valid && ld && m_rw && (m_rd != 0) && v && (rs1 == m_rd || rs2 == m_rd);
    e_ready = e_flush ? 1'b1 : (e_redir || (!e_haz && (!m_valid || e_ret)));
    e_en    = v && e_ready && !e_redir && !e_flush;
    check("mem_valid", 32'(mem_valid), 32'(m_valid));
    check("id_ready",  32'(id_ready),  32'(e_ready));
    check("redirect",  32'(redirect),  32'(e_redir));
    check("flush",     32'(flush),     32'(e_flush));
    check("ex_en",     32'(ex_en),     32'(e_en));
    check("ex_op",     32'(ex_op),     32'(m_op));
`ifdef EX_PERF_CNT_EN
    check("bubble_cnt", bubble_cnt, 32'(m_bubbles));
    check("flush_cnt",  flush_cnt,  32'(m_flushes));
`endif
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_op = 0; m_rd = 0; m_rw = 0; flush_left = 0;
      m_bubbles = 0; m_flushes = 0;
    end else begin
      if (e_haz && !e_redir) m_bubbles = (m_bubbles + 1) % 64'h1_0000_0000;
      if (e_redir) begin
        m_flushes = (m_flushes + 1) % 64'h1_0000_0000;
        m_valid = 0;
        flush_left = FC;
      end else if (e_flush) begin
        flush_left--;
      end else if (e_en) begin
        m_valid = 1; m_op = op; m_rd = rd; m_rw = rw;
      end else if (e_ret) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic idle(input bit mr);
    cyc(0, 0, 0, 0, 0, 0, 0, mr, 0);
  endtask

  initial begin
    m_valid = 0; m_op = 0; m_rd = 0; m_rw = 0; flush_left = 0;
    m_bubbles = 0; m_flushes = 0;
    rst = 1; id_valid = 0; id_op = '0; id_rd = 5'd0; id_rw = 0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; alu_branch = 0; mem_ready = 1;
    @(posedge clk);
    @(posedge clk);
    // reset state is checked by the first idle cycle
    idle(1);
    // back-to-back ADD, ADDI
    cyc(1, 0, 6, 1, 1, 2, 0, 1, 0);
    cyc(1, 1, 7, 1, 1, 2, 0, 1, 0);
    idle(1); idle(1);
    // LW x5 then ADD x6,x5,x1: one bubble
    cyc(1, 12, 5, 1, 1, 0, 0, 1, 0);
    cyc(1, 0, 6, 1, 5, 1, 0, 1, 0);
    cyc(1, 0, 6, 1, 5, 1, 0, 1, 0);
    idle(1);
    // same with rd = x0: no bubble
    cyc(1, 12, 0, 1, 1, 0, 0, 1, 0);
    cyc(1, 0, 6, 1, 0, 1, 0, 1, 0);
    idle(1);
    // store-class op never stalls
    cyc(1, 20, 5, 1, 1, 0, 0, 1, 0);
    cyc(1, 0, 6, 1, 5, 5, 0, 1, 0);
    idle(1);
    // taken BEQ with younger valid: redirect, two flush cycles, accept on cycle 4
    cyc(1, 4, 0, 0, 1, 2, 0, 1, 0);
    cyc(1, 0, 8, 1, 1, 2, 1, 1, 0);
    cyc(1, 0, 8, 1, 1, 2, 1, 1, 0);
    cyc(1, 0, 8, 1, 1, 2, 1, 1, 0);
    cyc(1, 0, 9, 1, 1, 2, 1, 1, 0);
    idle(1);
    // not-taken BNE, then JAL redirects regardless of branch input
    cyc(1, 5, 0, 0, 1, 2, 0, 1, 0);
    cyc(1, 2, 1, 1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1); idle(1); idle(1);
    // downstream stall for three cycles, retire on the fourth
    cyc(1, 0, 3, 1, 1, 2, 0, 1, 0);
    cyc(1, 1, 4, 1, 1, 2, 0, 0, 0);
    cyc(1, 1, 4, 1, 1, 2, 0, 0, 0);
    cyc(1, 1, 4, 1, 1, 2, 0, 0, 0);
    cyc(1, 1, 4, 1, 1, 2, 0, 1, 0);
    idle(1); idle(1);
    // reset in the first flush cycle
    cyc(1, 3, 1, 1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // stalled slot hit by reset
    cyc(1, 0, 3, 1, 1, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // randomized traffic with small register numbers so hazards are frequent
    for (int i = 0; i < 1500; i++) begin
      cyc(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 20)),
          int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
          bit'($urandom_range(0, 49) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
